// File: rtl/pkt_filter_pkg.sv
// Shared types and defaults for the packet-granular FIFO write controller.
package pkt_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_VERDICT,
    DISCARD
  } pkt_wr_state_t;

  localparam int CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Ingress stream, filter verdict, FIFO write port and status bundle of the packet writer.
// The writer sits on the slave side; the surrounding system (stream source, filter, FIFO) is the master.
interface fifo_pkt_writer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_EL       = 20,
  parameter int CNT_WIDTH  = 16
);

  logic [W_EL-1:0]       in_data;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_ready;
  logic                  verdict_valid;
  logic                  verdict_drop;
  logic [W_EL-1:0]       fifo_wdata;
  logic                  fifo_wen;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_wptr;
  logic                  fifo_wrst;
  logic [ADDR_WIDTH:0]   fifo_rst_wptr;
  logic [ADDR_WIDTH:0]   commit_ptr;
  logic                  commit_strobe;
  logic [CNT_WIDTH-1:0]  pkt_count;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready,
    input  verdict_valid, verdict_drop,
    output fifo_wdata, fifo_wen,
    input  fifo_full, fifo_wptr,
    output fifo_wrst, fifo_rst_wptr,
    output commit_ptr, commit_strobe, pkt_count, drop_count
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready,
    output verdict_valid, verdict_drop,
    input  fifo_wdata, fifo_wen,
    output fifo_full, fifo_wptr,
    input  fifo_wrst, fifo_rst_wptr,
    input  commit_ptr, commit_strobe, pkt_count, drop_count
  );

endinterface

// File: rtl/fifo_pkt_writer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_pkt_writer.sv
// Speculative packet writer: streams a packet into the FIFO, then commits it or rewinds the
// FIFO write pointer to the packet start depending on the filter verdict or an overflow.
module fifo_pkt_writer
  import pkt_filter_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int W_EL       = 20,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  fifo_pkt_writer_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;

  pkt_wr_state_t state, next_state;

  logic [PW-1:0]        start_ptr;
  logic [PW-1:0]        commit_ptr_q;
  logic                 commit_strobe_q;
  logic                 verdict_seen;
  logic                 verdict_is_drop;
  logic [W_EL-1:0]      wdata;
  logic [CNT_WIDTH-1:0] pkt_count_w;
  logic [CNT_WIDTH-1:0] drop_count_w;

  logic accepted;
  logic write_phase;
  logic sop_accept;
  logic wen;
  logic overflow;
  logic verdict_here;
  logic verdict_drop_eff;
  logic do_commit;
  logic do_drop;
  logic latch_load;

  always_comb begin
    next_state       = state;
    accepted         = bus.in_valid && (state != WAIT_VERDICT);
    write_phase      = ((state == IDLE) && bus.in_sop) || (state == WRITE);
    sop_accept       = accepted && (state == IDLE) && bus.in_sop;
    wen              = accepted && write_phase && !bus.fifo_full;
    overflow         = accepted && write_phase && bus.fifo_full;
    // An already latched verdict outranks anything strobed while waiting.
    verdict_here     = verdict_seen || bus.verdict_valid;
    verdict_drop_eff = verdict_seen ? verdict_is_drop : bus.verdict_drop;
    do_commit        = (state == WAIT_VERDICT) && verdict_here && !verdict_drop_eff;
    do_drop          = (state == WAIT_VERDICT) && verdict_here && verdict_drop_eff;
    latch_load       = bus.verdict_valid && !verdict_seen &&
                       (sop_accept || (state == WRITE) || (state == WAIT_VERDICT));

    case (state)
      IDLE, WRITE: begin
        if (accepted && write_phase) begin
          if (overflow) begin
            next_state = bus.in_eop ? IDLE : DISCARD;
          end else begin
            next_state = bus.in_eop ? WAIT_VERDICT : WRITE;
          end
        end
      end
      WAIT_VERDICT: begin
        if (verdict_here) begin
          next_state = IDLE;
        end
      end
      DISCARD: begin
        if (accepted && bus.in_eop) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      verdict_seen    <= 1'b0;
      verdict_is_drop <= 1'b0;
    end else if (do_commit || do_drop || overflow) begin
      verdict_seen    <= 1'b0;
      verdict_is_drop <= 1'b0;
    end else if (latch_load) begin
      verdict_seen    <= 1'b1;
      verdict_is_drop <= bus.verdict_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_ptr       <= '0;
      commit_ptr_q    <= '0;
      commit_strobe_q <= 1'b0;
    end else begin
      commit_strobe_q <= do_commit;
      if (sop_accept) begin
        start_ptr <= bus.fifo_wptr;
      end
      if (do_commit) begin
        commit_ptr_q <= bus.fifo_wptr;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_count (
    .clk   (clk),
    .reset (reset),
    .inc   (do_commit),
    .count (pkt_count_w)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_count (
    .clk   (clk),
    .reset (reset),
    .inc   (overflow || do_drop),
    .count (drop_count_w)
  );

  // An overflow on the sop beat itself has not yet loaded start_ptr; nothing was written, so the live pointer is the start.
  assign bus.fifo_rst_wptr = (state == IDLE) ? bus.fifo_wptr : start_ptr;

  assign wdata             = bus.in_data;
  assign bus.fifo_wdata    = wdata;
  assign bus.fifo_wen      = wen;
  assign bus.fifo_wrst     = overflow || do_drop;
  assign bus.in_ready      = (state != WAIT_VERDICT);
  assign bus.commit_ptr    = commit_ptr_q;
  assign bus.commit_strobe = commit_strobe_q;
  assign bus.pkt_count     = pkt_count_w;
  assign bus.drop_count    = drop_count_w;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer against a small FIFO pointer model (ADDR_WIDTH=9, no reads).
module tb_fifo_pkt_writer;

  localparam int ADDR_WIDTH = 9;
  localparam int W_EL       = 20;
  localparam int CNT_WIDTH  = 16;
  localparam int PW         = ADDR_WIDTH + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_pkt_writer_if #(.ADDR_WIDTH(ADDR_WIDTH), .W_EL(W_EL), .CNT_WIDTH(CNT_WIDTH)) bus ();

  fifo_pkt_writer #(.ADDR_WIDTH(ADDR_WIDTH), .W_EL(W_EL), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // FIFO write-pointer model; the reader never advances, so full means 2^ADDR_WIDTH words held.
  logic [PW-1:0] model_wptr;
  always_ff @(posedge clk) begin
    if (reset)              model_wptr <= '0;
    else if (bus.fifo_wrst) model_wptr <= bus.fifo_rst_wptr;
    else if (bus.fifo_wen)  model_wptr <= model_wptr + 1'b1;
  end
  assign bus.fifo_wptr = model_wptr;
  assign bus.fifo_full = (model_wptr == PW'(1 << ADDR_WIDTH));

  int tests_run    = 0;
  int tests_failed = 0;
  int data_seed    = 'h100;
  logic [W_EL-1:0] sb[$];

  typedef struct {
    logic v, s, e, vv, vd;
    logic wen, wrst, rdy;
    logic [PW-1:0] rw;
    logic [PW-1:0] cptr;
    logic stb;
    int pkt, drp;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, s, e, vv, vd, input logic exp_wen);
    bus.in_data       = data_seed[W_EL-1:0];
    data_seed++;
    bus.in_valid      = v;
    bus.in_sop        = s;
    bus.in_eop        = e;
    bus.verdict_valid = vv;
    bus.verdict_drop  = vd;
    if (exp_wen) sb.push_back(bus.in_data);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string name, input logic v, s, e, vv, vd,
                      input logic wen, wrst, rdy);
    applyStimulus(v, s, e, vv, vd, wen);
    checkOutput({name, ".wen"}, 32'(bus.fifo_wen), 32'(wen));
    checkOutput({name, ".wrst"}, 32'(bus.fifo_wrst), 32'(wrst));
    checkOutput({name, ".ready"}, 32'(bus.in_ready), 32'(rdy));
    tick();
  endtask

  task automatic checkRegs(input string name, input logic [PW-1:0] cptr, input logic stb,
                           input int pkt, input int drp);
    checkOutput({name, ".commit_ptr"}, 32'(bus.commit_ptr), 32'(cptr));
    checkOutput({name, ".strobe"}, 32'(bus.commit_strobe), 32'(stb));
    checkOutput({name, ".pkt_count"}, 32'(bus.pkt_count), pkt);
    checkOutput({name, ".drop_count"}, 32'(bus.drop_count), drp);
  endtask

  // Scoreboard: every FIFO write must carry the next expected word.
  always @(negedge clk) begin
    if (bus.fifo_wen && bus.fifo_wrst)
      checkOutput("wen_wrst_exclusive", 32'(bus.fifo_wrst), 32'd0);
    if (bus.fifo_wen) begin
      if (sb.size() == 0) checkOutput("unexpected_write", 32'(bus.fifo_wdata), 32'hFFFFFFFF);
      else                checkOutput("write_data", 32'(bus.fifo_wdata), 32'(sb.pop_front()));
    end
  end

  initial begin
    //                 v  s  e  vv vd wen wrst rdy rw cptr stb pkt drp
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 1, 1, 0});
    vecs.push_back(vec_t'{1, 1, 0, 1, 1, 1, 0, 1, 0, 4, 0, 1, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 0, 1, 0, 1, 0, 4, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 1, 0, 4, 4, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 1, 1});
    vecs.push_back(vec_t'{1, 1, 1, 0, 0, 1, 0, 1, 0, 4, 0, 1, 1});
    vecs.push_back(vec_t'{1, 1, 0, 1, 0, 0, 0, 0, 0, 4, 0, 1, 1});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 1, 0, 1, 0, 5, 1, 2, 1});
    vecs.push_back(vec_t'{1, 0, 1, 0, 0, 1, 0, 1, 0, 5, 0, 2, 1});
    vecs.push_back(vec_t'{0, 0, 0, 1, 1, 0, 1, 0, 5, 5, 0, 2, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{1, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{1, 1, 0, 1, 0, 1, 0, 1, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{1, 0, 1, 1, 1, 1, 0, 1, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{0, 0, 0, 1, 1, 0, 0, 0, 0, 5, 0, 2, 2});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 3, 2});
    vecs.push_back(vec_t'{0, 0, 0, 1, 1, 0, 0, 1, 0, 7, 0, 3, 2});
    vecs.push_back(vec_t'{1, 1, 1, 0, 0, 1, 0, 1, 0, 7, 0, 3, 2});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 3, 2});
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 3, 2});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 1, 4, 2});

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checkOutput("reset.wen", 32'(bus.fifo_wen), 0);
    checkOutput("reset.wrst", 32'(bus.fifo_wrst), 0);
    checkOutput("reset.ready", 32'(bus.in_ready), 1);
    checkRegs("reset", 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].vv, vecs[i].vd, vecs[i].wen);
      checkOutput($sformatf("r%0d.wen", i), 32'(bus.fifo_wen), 32'(vecs[i].wen));
      checkOutput($sformatf("r%0d.wrst", i), 32'(bus.fifo_wrst), 32'(vecs[i].wrst));
      checkOutput($sformatf("r%0d.ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      if (vecs[i].wrst)
        checkOutput($sformatf("r%0d.rst_wptr", i), 32'(bus.fifo_rst_wptr), 32'(vecs[i].rw));
      checkRegs($sformatf("r%0d", i), vecs[i].cptr, vecs[i].stb, vecs[i].pkt, vecs[i].drp);
      tick();
    end

    // Reset after word 2 of a 5-word packet; the tail without sop must be discarded.
    beat("rst.w0", 1, 1, 0, 0, 0, 1, 0, 1);
    beat("rst.w1", 1, 0, 0, 0, 0, 1, 0, 1);
    beat("rst.w2", 1, 0, 0, 0, 0, 1, 0, 1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    checkOutput("rst.wen", 32'(bus.fifo_wen), 0);
    checkOutput("rst.wrst", 32'(bus.fifo_wrst), 0);
    checkOutput("rst.ready", 32'(bus.in_ready), 1);
    checkRegs("rst", 0, 0, 0, 0);
    beat("rst.w3", 1, 0, 0, 0, 0, 0, 0, 1);
    beat("rst.w4", 1, 0, 1, 0, 0, 0, 0, 1);

    // Fill the 512-entry FIFO with 510 committed words.
    for (int i = 0; i < 510; i++) begin
      applyStimulus(1, i == 0, i == 509, 0, 0, 1);
      tick();
    end
    beat("fill.verdict", 0, 0, 0, 1, 0, 0, 0, 0);
    checkRegs("fill", 510, 1, 1, 0);

    // 5-word packet: third word hits full, rewind to 510, tail discarded.
    beat("ovf.w0", 1, 1, 0, 0, 0, 1, 0, 1);
    beat("ovf.w1", 1, 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("ovf.w2.wen", 32'(bus.fifo_wen), 0);
    checkOutput("ovf.w2.wrst", 32'(bus.fifo_wrst), 1);
    checkOutput("ovf.w2.rst_wptr", 32'(bus.fifo_rst_wptr), 510);
    tick();
    beat("ovf.w3", 1, 0, 0, 1, 0, 0, 0, 1);
    beat("ovf.w4", 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkRegs("ovf", 510, 0, 1, 1);

    // Next packet must start at the restored pointer 510.
    beat("post.w0", 1, 1, 1, 0, 0, 1, 0, 1);
    beat("post.verdict", 0, 0, 0, 1, 0, 0, 0, 0);
    checkRegs("post", 511, 1, 2, 1);

    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checkOutput("sb.empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
